// File: rtl/zx_vram_pkg.sv
// Shared types and default sizing for the ZX video RAM arbiter.
package zx_vram_pkg;

  localparam int AW_DEF       = 15;
  localparam int MAX_WAIT_DEF = 16;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    VID  = 2'd1,
    CPU  = 2'd2,
    DMA  = 2'd3
  } owner_t;

endpackage

// File: rtl/zx_vram_age_cnt.sv
// Saturating DMA starvation counter; at_max lets the loader outrank the CPU.
module zx_vram_age_cnt
  import zx_vram_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic i_clk_sys,
  input  logic i_reset,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_at_max
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk_sys) begin
    if (i_reset || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != CW'(MAX_WAIT))) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_at_max = (r_cnt == CW'(MAX_WAIT));

endmodule

// File: rtl/zx_vram_arbiter.sv
// Video RAM arbiter: one grant per cycle, video > CPU > DMA, fixed 2-cycle pipe.
// owner | meaning: NONE idle slot | VID ULA fetch | CPU bus cycle | DMA loader write
module zx_vram_arbiter
  import zx_vram_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic          i_clk_sys,
  input  logic          i_reset,
  input  logic          i_vid_req,
  input  logic [AW-1:0] i_vid_addr,
  output logic [7:0]    o_vid_data,
  output logic          o_vid_valid,
  input  logic          i_cpu_req,
  input  logic          i_cpu_we,
  input  logic [AW-1:0] i_cpu_addr,
  input  logic [7:0]    i_cpu_din,
  output logic [7:0]    o_cpu_dout,
  output logic          o_cpu_ack,
  input  logic          i_dma_req,
  input  logic [AW-1:0] i_dma_addr,
  input  logic [7:0]    i_dma_din,
  output logic          o_dma_ack,
  output logic [AW-1:0] o_ram_addr,
  output logic [7:0]    o_ram_din,
  output logic          o_ram_we,
  input  logic [7:0]    i_ram_dout
);

  owner_t        w_win;
  owner_t        r_owner1;
  owner_t        r_owner2;
  logic          w_cpu_el;
  logic          w_dma_el;
  logic          w_at_max;
  logic          r_cpu_busy;
  logic          r_dma_busy;
  logic          r_wr2;
  logic [AW-1:0] r_ram_addr;
  logic [7:0]    r_ram_din;
  logic          r_ram_we;
  logic [7:0]    r_vid_hold;
  logic [7:0]    r_cpu_hold;

  assign w_cpu_el = i_cpu_req & ~r_cpu_busy;
  assign w_dma_el = i_dma_req & ~r_dma_busy;

  // Aging only lifts the loader above the CPU; video is never preempted.
  always_comb begin
    w_win = NONE;
    if (i_vid_req) begin
      w_win = VID;
    end else if (w_dma_el && w_at_max) begin
      w_win = DMA;
    end else if (w_cpu_el) begin
      w_win = CPU;
    end else if (w_dma_el) begin
      w_win = DMA;
    end
  end

  zx_vram_age_cnt #(
    .MAX_WAIT (MAX_WAIT)
  ) u_age_cnt (
    .i_clk_sys (i_clk_sys),
    .i_reset   (i_reset),
    .i_inc     (w_dma_el && (w_win != DMA)),
    .i_clr     ((w_win == DMA) || !i_dma_req),
    .o_at_max  (w_at_max)
  );

  always_ff @(posedge i_clk_sys) begin
    if (i_reset) begin
      r_owner1   <= NONE;
      r_ram_addr <= '0;
      r_ram_din  <= '0;
      r_ram_we   <= 1'b0;
    end else begin
      r_owner1 <= w_win;
      case (w_win)
        VID: begin
          r_ram_addr <= i_vid_addr;
          r_ram_we   <= 1'b0;
        end
        CPU: begin
          r_ram_addr <= i_cpu_addr;
          r_ram_din  <= i_cpu_din;
          r_ram_we   <= i_cpu_we;
        end
        DMA: begin
          r_ram_addr <= i_dma_addr;
          r_ram_din  <= i_dma_din;
          r_ram_we   <= 1'b1;
        end
        default: r_ram_we <= 1'b0;
      endcase
    end
  end

  always_ff @(posedge i_clk_sys) begin
    if (i_reset) begin
      r_owner2   <= NONE;
      r_wr2      <= 1'b0;
      r_vid_hold <= '0;
      r_cpu_hold <= '0;
    end else begin
      r_owner2 <= r_owner1;
      r_wr2    <= r_ram_we;
      if (o_vid_valid) r_vid_hold <= i_ram_dout;
      if (o_cpu_ack && !r_wr2) r_cpu_hold <= i_ram_dout;
    end
  end

  // Busy drops on the ack edge, so a held request is seen again only at ack+1.
  always_ff @(posedge i_clk_sys) begin
    if (i_reset) begin
      r_cpu_busy <= 1'b0;
      r_dma_busy <= 1'b0;
    end else begin
      if (w_win == CPU) r_cpu_busy <= 1'b1;
      else if (o_cpu_ack) r_cpu_busy <= 1'b0;
      if (w_win == DMA) r_dma_busy <= 1'b1;
      else if (o_dma_ack) r_dma_busy <= 1'b0;
    end
  end

  assign o_vid_valid = (r_owner2 == VID);
  assign o_cpu_ack   = (r_owner2 == CPU);
  assign o_dma_ack   = (r_owner2 == DMA);
  assign o_vid_data  = o_vid_valid ? i_ram_dout : r_vid_hold;
  assign o_cpu_dout  = (o_cpu_ack && !r_wr2) ? i_ram_dout : r_cpu_hold;
  assign o_ram_addr  = r_ram_addr;
  assign o_ram_din   = r_ram_din;
  assign o_ram_we    = r_ram_we;

endmodule
